// File: rtl/layer_node_sequencer.sv
// layer_node_sequencer: streaming front/back end for one combinational float
// neuron node. It collects NUM_IN activation words into a parallel bank that
// drives the node inputs. It then waits SETTLE_CYCLES for the node to settle,
// captures the node result, and presents that result on a valid/ready stream.
module layer_node_sequencer #(
  parameter int NUM_IN        = 15,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [NUM_IN*32-1:0] a_bus,
  input  logic [31:0]          node_result,
  output logic [31:0]          res_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic [CNT_W-1:0]     frame_cnt
);

  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_IN - 1);
  localparam logic [SET_W-1:0] SETTLE_TOP = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic [31:0]       bank [NUM_IN];

  // The bank drives the node inputs directly, with word k on node input Ak.
  for (genvar k = 0; k < NUM_IN; k++) begin : g_bus
    assign a_bus[32*k +: 32] = bank[k];
  end

  // Words are accepted only in LOAD. This keeps the bank frozen while the node
  // settles and while the result waits downstream, so frames never overlap.
  assign in_ready = (state == LOAD);
  assign busy     = !((state == LOAD) && (cnt == '0));

  // Sequencer: load bank, wait for the node to settle, hold result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the bank is a register array, not a RAM, and it is cleared on
      // reset because a_bus must read as zero right after reset.
      for (int k = 0; k < NUM_IN; k++) begin
        bank[k] <= '0;
      end
      state      <= LOAD;
      cnt        <= '0;
      settle_cnt <= '0;
      res_data   <= '0;
      res_valid  <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments. Every branch then
      // reads the pre-edge values, whatever order the statements appear in.
      case (state)
        LOAD: begin
          if (in_valid) begin
            bank[cnt] <= in_data;
            if (cnt == LAST_IDX) begin
              // Final word of the frame. A missing in_last is flagged,
              // but the frame is still evaluated.
              cnt        <= '0;
              settle_cnt <= SETTLE_TOP;
              state      <= SETTLE;
              if (!in_last) frame_err <= 1'b1;
            end else if (in_last) begin
              // Early last: drop the partial frame. Stale bank words are
              // overwritten by the next frame.
              cnt       <= '0;
              frame_err <= 1'b1;
            end else begin
              cnt <= cnt + IDX_W'(1);
            end
          end
        end

        SETTLE: begin
          if (settle_cnt == '0) begin
            res_data  <= node_result;
            res_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            settle_cnt <= settle_cnt - SET_W'(1);
          end
        end

        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            frame_cnt <= frame_cnt + CNT_W'(1);
            state     <= LOAD;
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule
